// File: rtl/sisc_ctrl.sv
// Multi-cycle control unit for the SISC processor: sequences each instruction
// through fetch/decode/execute/mem/writeback and drives the datapath strobes.
module sisc_ctrl #(
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_f,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] mm,
    input  logic [OPW-1:0] stat,
    output logic           pc_rst,
    output logic           pc_write,
    output logic           pc_sel,
    output logic           br_sel,
    output logic           ir_load,
    output logic [1:0]     alu_op,
    output logic           stat_en,
    output logic           mem_we,
    output logic           wb_sel,
    output logic           rf_we,
    output logic           halted
);

    localparam logic [OPW-1:0] OP_ALU_REG = OPW'(1);
    localparam logic [OPW-1:0] OP_ALU_IMM = OPW'(2);
    localparam logic [OPW-1:0] OP_BRA     = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR     = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE     = OPW'(6);
    localparam logic [OPW-1:0] OP_BNR     = OPW'(7);
    localparam logic [OPW-1:0] OP_LOD     = OPW'(8);
    localparam logic [OPW-1:0] OP_STR     = OPW'(9);
    localparam logic [OPW-1:0] OP_HLT     = OPW'(15);

    typedef enum logic [2:0] {
        START0,
        START1,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT
    } state_t;

    state_t state;

    logic       is_branch;
    logic       is_relative;
    logic       cond_hit;
    logic       br_taken;
    logic [1:0] alu_mode;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state <= START0;
        end else begin
            case (state)
                START0:    state <= START1;
                START1:    state <= FETCH;
                FETCH:     state <= DECODE;
                DECODE:    state <= (opcode == OP_HLT) ? HALT : EXECUTE;
                EXECUTE:   state <= MEM;
                MEM:       state <= WRITEBACK;
                WRITEBACK: state <= FETCH;
                HALT:      state <= HALT;
                default:   state <= START0;
            endcase
        end
    end

    // BRA/BRR branch when any masked flag is set (or the mask is empty);
    // BNE/BNR branch when no masked flag is set.
    assign is_branch   = (opcode == OP_BRA) || (opcode == OP_BRR) ||
                         (opcode == OP_BNE) || (opcode == OP_BNR);
    assign is_relative = (opcode == OP_BRR) || (opcode == OP_BNR);
    assign cond_hit    = |(mm & stat);
    assign br_taken    = ((opcode == OP_BRA) || (opcode == OP_BRR)) ?
                         ((mm == '0) || cond_hit) : !cond_hit;

    always_comb begin
        alu_mode = 2'b00;
        if (opcode == OP_ALU_IMM)
            alu_mode = 2'b01;
        else if ((opcode == OP_LOD) || (opcode == OP_STR))
            alu_mode = 2'b10;
    end

    always_comb begin
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        ir_load  = 1'b0;
        alu_op   = 2'b00;
        stat_en  = 1'b0;
        mem_we   = 1'b0;
        wb_sel   = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;
        case (state)
            START0: pc_rst = 1'b1;
            FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
            end
            DECODE: begin
                if (is_branch) begin
                    br_sel   = is_relative;
                    pc_write = br_taken;
                    pc_sel   = br_taken;
                end
            end
            EXECUTE: begin
                alu_op  = alu_mode;
                stat_en = (opcode == OP_ALU_REG) || (opcode == OP_ALU_IMM);
            end
            MEM: begin
                alu_op = alu_mode;
                mem_we = (opcode == OP_STR);
            end
            WRITEBACK: begin
                alu_op = alu_mode;
                rf_we  = (opcode == OP_ALU_REG) || (opcode == OP_ALU_IMM) ||
                         (opcode == OP_LOD);
                wb_sel = (opcode == OP_LOD);
            end
            HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl.sv
// Scoreboard bench for sisc_ctrl: stimulus pushes per-cycle expected strobes,
// a negedge monitor pops and compares them against the DUT.
module tb_sisc_ctrl;

    typedef struct packed {
        logic       pc_rst;
        logic       pc_write;
        logic       pc_sel;
        logic       br_sel;
        logic       ir_load;
        logic [1:0] alu_op;
        logic       stat_en;
        logic       mem_we;
        logic       wb_sel;
        logic       rf_we;
        logic       halted;
    } ctl_t;

    typedef struct packed {
        logic [3:0] phase;
        logic [3:0] op;
        ctl_t       ctl;
    } entry_t;

    localparam logic [3:0] PH_FETCH  = 4'd0;
    localparam logic [3:0] PH_DECODE = 4'd1;
    localparam logic [3:0] PH_EXEC   = 4'd2;
    localparam logic [3:0] PH_MEM    = 4'd3;
    localparam logic [3:0] PH_WB     = 4'd4;
    localparam logic [3:0] PH_HALT   = 4'd5;
    localparam logic [3:0] PH_START0 = 4'd6;
    localparam logic [3:0] PH_START1 = 4'd7;

    logic       clk;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       pc_rst, pc_write, pc_sel, br_sel, ir_load;
    logic [1:0] alu_op;
    logic       stat_en, mem_we, wb_sel, rf_we, halted;

    int checks = 0;
    int failures = 0;
    entry_t exp_q[$];

    sisc_ctrl #(.OPW(4)) dut (
        .clk(clk), .rst_f(rst_f), .opcode(opcode), .mm(mm), .stat(stat),
        .pc_rst(pc_rst), .pc_write(pc_write), .pc_sel(pc_sel), .br_sel(br_sel),
        .ir_load(ir_load), .alu_op(alu_op), .stat_en(stat_en), .mem_we(mem_we),
        .wb_sel(wb_sel), .rf_we(rf_we), .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: what each instruction phase should drive, from the ISA rules.
    function automatic ctl_t model(logic [3:0] phase, logic [3:0] op,
                                   logic [3:0] m, logic [3:0] s);
        ctl_t c = '0;
        int   opn = int'(op);
        bit   is_alu = (opn == 1) || (opn == 2);
        bit   taken;
        case (phase)
            PH_START0: c.pc_rst = 1'b1;
            PH_FETCH: begin
                c.ir_load  = 1'b1;
                c.pc_write = 1'b1;
            end
            PH_DECODE: begin
                if (opn >= 4 && opn <= 7) begin
                    if (opn <= 5) taken = (m == 4'd0) || ((m & s) != 4'd0);
                    else          taken = ((m & s) == 4'd0);
                    c.br_sel   = (opn == 5) || (opn == 7);
                    c.pc_write = taken;
                    c.pc_sel   = taken;
                end
            end
            PH_EXEC, PH_MEM, PH_WB: begin
                if (opn == 2)                  c.alu_op = 2'b01;
                else if (opn == 8 || opn == 9) c.alu_op = 2'b10;
                if (phase == PH_EXEC) c.stat_en = is_alu;
                if (phase == PH_MEM)  c.mem_we  = (opn == 9);
                if (phase == PH_WB) begin
                    c.rf_we  = is_alu || (opn == 8);
                    c.wb_sel = (opn == 8);
                end
            end
            PH_HALT: c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t sample();
        return '{pc_rst, pc_write, pc_sel, br_sel, ir_load, alu_op,
                 stat_en, mem_we, wb_sel, rf_we, halted};
    endfunction

    task automatic checkOutput(string name, ctl_t expected);
        ctl_t actual = sample();
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%b required=%b (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic pushPhase(logic [3:0] phase);
        entry_t e;
        e.phase = phase;
        e.op    = opcode;
        e.ctl   = model(phase, opcode, mm, stat);
        exp_q.push_back(e);
    endtask

    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput($sformatf("phase%0d_op%h", e.phase, e.op), e.ctl);
            end
        end
    end

    // Asserts reset off-edge, checks the immediate START0 response, then
    // releases and lines up at the first FETCH cycle.
    task automatic doReset(string name);
        rst_f = 1'b0;
        #1;
        checkOutput(name, model(PH_START0, 4'd0, 4'd0, 4'd0));
        #20;
        @(negedge clk);
        #2;
        rst_f = 1'b1;
        pushPhase(PH_START1);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    // Called one time unit into FETCH; returns one time unit into next FETCH.
    task automatic applyStimulus(logic [3:0] op, logic [3:0] m, logic [3:0] s);
        opcode = op;
        mm     = m;
        stat   = s;
        for (int p = 0; p < 5; p++) pushPhase(4'(p));
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic resetMidExecute(logic [3:0] op);
        opcode = op;
        mm     = 4'd0;
        stat   = 4'd0;
        pushPhase(PH_FETCH);
        pushPhase(PH_DECODE);
        pushPhase(PH_EXEC);
        repeat (2) @(posedge clk);
        #7;
        doReset("reset_mid_execute");
    endtask

    task automatic haltAndReset();
        opcode = 4'hF;
        mm     = 4'($urandom_range(0, 15));
        stat   = 4'($urandom_range(0, 15));
        pushPhase(PH_FETCH);
        pushPhase(PH_DECODE);
        for (int i = 0; i < 12; i++) pushPhase(PH_HALT);
        repeat (14) @(posedge clk);
        #2;
        doReset("reset_in_halt");
    endtask

    task automatic randomInstr();
        logic [3:0] op = 4'($urandom_range(0, 14));
        logic [3:0] m  = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        logic [3:0] s  = 4'($urandom_range(0, 15));
        applyStimulus(op, m, s);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_f  = 1'b1;
        opcode = 4'd0;
        mm     = 4'd0;
        stat   = 4'd0;
        #3;
        doReset("reset_start0");

        applyStimulus(4'h2, 4'h0, 4'h0);
        applyStimulus(4'h5, 4'h1, 4'h1);
        applyStimulus(4'h5, 4'h1, 4'h0);
        applyStimulus(4'h6, 4'h4, 4'h4);
        applyStimulus(4'h6, 4'h4, 4'h0);
        applyStimulus(4'h4, 4'h0, 4'h0);
        applyStimulus(4'h7, 4'h3, 4'h8);
        applyStimulus(4'h8, 4'h0, 4'h0);
        applyStimulus(4'h9, 4'h0, 4'h0);
        applyStimulus(4'h1, 4'h0, 4'hF);

        for (int i = 0; i < 60; i++) randomInstr();

        resetMidExecute(4'h1);
        for (int i = 0; i < 5; i++) randomInstr();

        haltAndReset();
        applyStimulus(4'h2, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) randomInstr();
        haltAndReset();

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
